// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: EX-stage <-> multiply/divide unit bundle.
//   master (EX side) drives: start, md_op, A, B, cancel, hi_we, lo_we, wdata
//   slave (alu_muldiv) drives: busy, done, div_zero, hi, lo
interface alu_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [3:0]            md_op;   // one-hot: [3] mult, [2] multu, [1] div, [0] divu
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  cancel;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, md_op, A, B, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, md_op, A, B, cancel, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MIPS mult/multu/div/divu unit with HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle; signed ops run on magnitudes and are sign-fixed in a final cycle.
// Ports:
//   clk    - rising-edge clock
//   resetn - synchronous active-low reset
//   bus    - alu_muldiv_if.slave: start/md_op/A/B launch, cancel flush,
//            hi_we/lo_we/wdata for mthi/mtlo, busy/done/div_zero status,
//            hi/lo architectural registers
module alu_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         resetn,
  alu_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           op_mul;
  logic           sa;
  logic           sb;
  logic           b_zero;
  logic [2*W-1:0] prod;    // multiply: {acc, multiplier}; divide: low half is dividend/quotient
  logic [W-1:0]   opb;     // multiplicand or divisor magnitude
  logic [W:0]     rem;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           busy_q;
  logic           done_q;
  logic           dz_q;

  logic           md_valid;
  logic           in_mul;
  logic           in_signed;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W:0]     add_sum;
  logic [W+1:0]   shifted;
  logic [W+1:0]   trial;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    md_valid  = (bus.md_op != 4'b0000) && ((bus.md_op & (bus.md_op - 4'd1)) == 4'b0000);
    in_mul    = bus.md_op[3] | bus.md_op[2];
    in_signed = bus.md_op[3] | bus.md_op[1];
    // Negating the most-negative value yields 2^(W-1), which is the correct
    // unsigned magnitude in W bits.
    mag_a     = (in_signed && bus.A[W-1]) ? -bus.A : bus.A;
    mag_b     = (in_signed && bus.B[W-1]) ? -bus.B : bus.B;

    add_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, opb};
    shifted   = {rem, prod[W-1]};
    trial     = shifted - {2'b00, opb};

    prod_fix  = (sa ^ sb) ? -prod : prod;
    quo_fix   = b_zero ? '1 : ((sa ^ sb) ? -prod[W-1:0] : prod[W-1:0]);
    // With a zero divisor the remainder ends as |A|; re-applying A's sign
    // returns A exactly, so no special case is needed for HI.
    rem_fix   = sa ? -rem[W-1:0] : rem[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_mul <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      b_zero <= 1'b0;
      prod   <= '0;
      opb    <= '0;
      rem    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start && !bus.cancel && md_valid) begin
            op_mul <= in_mul;
            sa     <= in_signed & bus.A[W-1];
            sb     <= in_signed & bus.B[W-1];
            b_zero <= !in_mul && (bus.B == '0);
            prod   <= {{W{1'b0}}, mag_a};
            opb    <= mag_b;
            rem    <= '0;
            cnt    <= CW'(W);
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          if (bus.cancel) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            if (op_mul) begin
              if (prod[0]) prod <= {add_sum, prod[W-1:1]};
              else         prod <= {1'b0, prod[2*W-1:1]};
            end else begin
              if (!trial[W+1]) begin
                rem          <= trial[W:0];
                prod[W-1:0]  <= {prod[W-2:0], 1'b1};
              end else begin
                rem          <= shifted[W:0];
                prod[W-1:0]  <= {prod[W-2:0], 1'b0};
              end
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end

        S_FIX: begin
          if (bus.cancel) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            if (op_mul) begin
              {hi_q, lo_q} <= prod_fix;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
            done_q <= 1'b1;
            dz_q   <= b_zero;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic resetn;

  alu_muldiv_if #(.DATA_WIDTH(W)) bus_if ();
  alu_muldiv #(.DATA_WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus_if));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  // Reference model: cycles left until the unit is idle again, plus the
  // architectural HI/LO and the pending result of the accepted operation.
  int           m_left = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  logic [W-1:0] p_hi   = '0;
  logic [W-1:0] p_lo   = '0;
  bit           p_dz   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic reference(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
    longint          sp, sq, sr;
    longint unsigned up;
    logic [63:0]     v;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      4'b1000: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        v  = sp;
        h  = v[63:32];
        l  = v[31:0];
      end
      4'b0100: begin
        up = {32'b0, a} * {32'b0, b};
        v  = up;
        h  = v[63:32];
        l  = v[31:0];
      end
      4'b0010: begin
        if (b == '0) begin
          l = '1; h = a; dz = 1'b1;
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          v  = sq; l = v[31:0];
          v  = sr; h = v[31:0];
        end
      end
      default: begin
        if (b == '0) begin
          l = '1; h = a; dz = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      if (bus_if.cancel) m_left = 0;
      else begin
        m_left--;
        if (m_left == 1) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else begin
      if (bus_if.hi_we) m_hi = bus_if.wdata;
      if (bus_if.lo_we) m_lo = bus_if.wdata;
      if (bus_if.start && !bus_if.cancel && $countones(bus_if.md_op) == 1) begin
        reference(bus_if.md_op, bus_if.A, bus_if.B, p_hi, p_lo, p_dz);
        m_left = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, bus_if.busy}, {63'b0, (m_left > 0)});
      check("done", {63'b0, bus_if.done}, {63'b0, (m_left == 1)});
      check("div_zero", {63'b0, bus_if.div_zero}, {63'b0, (m_left == 1) && p_dz});
      check("hi", {32'b0, bus_if.hi}, {32'b0, m_hi});
      check("lo", {32'b0, bus_if.lo}, {32'b0, m_lo});
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation and wait (bounded) for done; optionally re-pulse
  // start with a different operation at cycle 'poke' while busy.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dz, input int poke);
    int n;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.md_op = op;
    bus_if.A     = a;
    bus_if.B     = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    n = 1;
    while (!bus_if.done && n < LAT + 10) begin
      @(negedge clk);
      n++;
      bus_if.start = (poke != 0) && (n == poke);
      if (bus_if.start) begin
        bus_if.md_op = 4'b0001;
        bus_if.B     = '0;
      end
    end
    bus_if.start = 1'b0;
    check({name, " latency"}, 64'(n), 64'(LAT));
    check({name, " hi"}, {32'b0, bus_if.hi}, {32'b0, exp_hi});
    check({name, " lo"}, {32'b0, bus_if.lo}, {32'b0, exp_lo});
    check({name, " div_zero"}, {63'b0, bus_if.div_zero}, {63'b0, exp_dz});
    check({name, " model hi"}, {32'b0, m_hi}, {32'b0, exp_hi});
    check({name, " model lo"}, {32'b0, m_lo}, {32'b0, exp_lo});
  endtask

  initial begin
    int  r;
    bit  seen;
    bus_if.start  = 1'b0;
    bus_if.md_op  = 4'b0;
    bus_if.A      = '0;
    bus_if.B      = '0;
    bus_if.cancel = 1'b0;
    bus_if.hi_we  = 1'b0;
    bus_if.lo_we  = 1'b0;
    bus_if.wdata  = '0;
    resetn        = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset hi", {32'b0, bus_if.hi}, 64'd0);
    check("reset lo", {32'b0, bus_if.lo}, 64'd0);
    check("reset busy", {63'b0, bus_if.busy}, 64'd0);
    check("reset done", {63'b0, bus_if.done}, 64'd0);
    resetn = 1'b1;

    run_op("mult",   4'b1000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0);
    run_op("multu",  4'b0100, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 0);
    run_op("div neg", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("divu 0", 4'b0001, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div ovf", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
    run_op("busy start", 4'b1000, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 5);

    // Invalid one-hot select is ignored.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.md_op = 4'b0011;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("bad md_op busy", {63'b0, bus_if.busy}, 64'd0);

    // mthi then cancelled multiply.
    bus_if.hi_we = 1'b1;
    bus_if.wdata = 32'h1234;
    @(negedge clk);
    bus_if.hi_we = 1'b0;
    check("mthi", {32'b0, bus_if.hi}, 64'h1234);
    bus_if.start = 1'b1;
    bus_if.md_op = 4'b1000;
    bus_if.A     = 32'd5;
    bus_if.B     = 32'd5;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (9) @(negedge clk);
    bus_if.cancel = 1'b1;
    @(negedge clk);
    bus_if.cancel = 1'b0;
    check("cancel busy", {63'b0, bus_if.busy}, 64'd0);
    check("cancel hi", {32'b0, bus_if.hi}, 64'h1234);
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus_if.done) seen = 1'b1;
    end
    check("cancel no done", {63'b0, seen}, 64'd0);

    // Reset in the middle of RUN.
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrun reset hi", {32'b0, bus_if.hi}, 64'd0);
    check("midrun reset lo", {32'b0, bus_if.lo}, 64'd0);
    check("midrun reset busy", {63'b0, bus_if.busy}, 64'd0);
    check("midrun reset done", {63'b0, bus_if.done}, 64'd0);
    check("midrun reset dz", {63'b0, bus_if.div_zero}, 64'd0);
    resetn = 1'b1;

    // Randomised traffic against the model.
    repeat (4000) begin
      @(negedge clk);
      bus_if.start  = ($urandom_range(0, 3) == 0);
      r             = $urandom_range(0, 9);
      bus_if.md_op  = (r < 8) ? (4'b0001 << r[1:0]) : 4'($urandom);
      bus_if.A      = pick();
      bus_if.B      = pick();
      bus_if.cancel = ($urandom_range(0, 79) == 0);
      bus_if.hi_we  = ($urandom_range(0, 7) == 0);
      bus_if.lo_we  = ($urandom_range(0, 7) == 0);
      bus_if.wdata  = $urandom;
      resetn        = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.cancel = 1'b0;
    bus_if.hi_we  = 1'b0;
    bus_if.lo_we  = 1'b0;
    resetn        = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised iterative multiply/divide unit that extends the pipeline's single-cycle ALU with MIPS `mult`/`multu`/`div`/`divu` and the architectural HI/LO registers. It sits beside the EX-stage ALU. EX launches an operation with a one-cycle `start` pulse and stalls on `busy`. WB/EX read `hi`/`lo` directly for `mfhi`/`mflo`, and `mthi`/`mtlo` write them through dedicated write ports. One shift-add or shift-subtract step is performed per cycle.

## Interface
- `DATA_WIDTH`, default 32: operand and HI/LO width. Must be even and ≥ 4.
- `clk` input 1: rising-edge clock.
- `resetn` input 1: synchronous, active-low reset.
- `start` input 1: launch request. Sampled only in IDLE.
- `md_op` input 4: one-hot operation select, sampled with `start`.
  - [3] `mult`
  - [2] `multu`
  - [1] `div`
  - [0] `divu`
- `A` input DATA_WIDTH: multiplicand or dividend (rs), sampled with `start`.
- `B` input DATA_WIDTH: multiplier or divisor (rt), sampled with `start`.
- `cancel` input 1: flush. Aborts any in-flight operation.
- `hi_we` input 1: write enable for HI (`mthi`).
- `lo_we` input 1: write enable for LO (`mtlo`).
- `wdata` input DATA_WIDTH: data for `hi_we`/`lo_we`.
- `busy` output 1: high from the cycle after acceptance until `done` is high.
- `done` output 1: one-cycle pulse. HI/LO hold the new result in this cycle.
- `div_zero` output 1: pulses together with `done` when a divide had B == 0.
- `hi` output DATA_WIDTH: HI register.
- `lo` output DATA_WIDTH: LO register.

## Operation
**States:** IDLE, RUN, FIX, DONE.

**Iteration counter:** width `$clog2(DATA_WIDTH)+1`.

**IDLE**
- `start` & !`cancel` & exactly one `md_op` bit set → latch the operation.
- For signed ops, latch operand magnitudes plus sign bits: sA = A[W-1], sB = B[W-1]. Unsigned ops latch A and B unchanged.
- Go to RUN with the counter = DATA_WIDTH.
- `start` with zero or multiple `md_op` bits set is ignored.

**RUN** (one step per cycle; counter decrements; counter == 1 → FIX)
- Multiply: 2W-bit accumulator, shift-add on the multiplier LSB. The add must keep its carry.
- Divide: restoring, one quotient bit per cycle.
  - Remainder register is W+1 bits.
  - Trial subtract of the divisor; keep the result if it is non-negative.

**FIX** (one cycle)
- Signed multiply: negate the 2W product if sA ^ sB.
- Signed divide:
  - Negate the quotient if sA ^ sB.
  - Negate the remainder if sA.
- Write the result at the end of FIX:
  - Multiply: HI ← product[2W-1:W], LO ← product[W-1:0].
  - Divide: LO ← quotient, HI ← remainder.

**DONE**
- `done` = 1, `busy` = 1.
- Next state: IDLE.

**Divide by zero** (`div` or `divu`, B == 0)
- Runs the full latency.
- Result: LO ← all-ones, HI ← A as sampled (no sign fixup).
- `div_zero` = 1 in DONE.

**Signed overflow** (`div` of most-negative value by −1)
- Result: LO ← 1 followed by W−1 zeros (wraps), HI ← 0.
- No flag.

**HI/LO writes**
- `hi_we`/`lo_we` take effect at the clock edge only in IDLE. They are ignored in RUN, FIX and DONE; EX stalls on `busy`.
- `hi_we` and `lo_we` in the same cycle write both registers.
- `start` with `hi_we` in IDLE: the write is applied, then the operation's later result overwrites it.

**`cancel`**
- Any state → IDLE at the next edge.
- HI/LO are not written. If cancel arrives in DONE, HI/LO were already written at the end of FIX and keep that result; the `done` already visible in that cycle still counts.
- No further `done`.
- `cancel` with `start` in IDLE: not accepted.

## Timing
**Reset**
- `resetn` = 0 at an edge → IDLE, counter = 0.
- `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0.
- Reset overrides everything, including mid-RUN. The result is discarded.

**Latency** (start sampled at edge 0)
- RUN occupies cycles 1..W.
- FIX is cycle W+1.
- DONE is cycle W+2: `done` high, HI/LO valid.
- A new `start` can be accepted at the edge that ends DONE → IDLE, so the earliest sampled start is in cycle W+3.
- Back-to-back throughput: one operation per W+3 cycles.

**`busy`**
- High in cycles 1..W+2.
- `start` while `busy` is ignored and has no effect on the state.

**Output timing**
- `hi`/`lo` are registered.
- Values are stable outside the write edges: end of FIX, and IDLE writes.
- `done` and `div_zero` are registered state decodes; no combinational path from the inputs.

**Arithmetic**
- All operations are modulo 2^W per half.
- Magnitude conversion of the most-negative value yields 2^(W-1) unsigned, which must be handled without overflow.

## Test plan
All scenarios use W = 32.

- **Signed multiply:** `mult` A = 0xFFFFFFFE, B = 3 → `done` at cycle 34; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; `busy` high in cycles 1–34.
- **Unsigned multiply:** `multu` with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- **Signed divide with negative operand:** `div` A = 0xFFFFFFF9 (−7), B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **Divide by zero:** `divu` A = 7, B = 0 → LO = 0xFFFFFFFF, HI = 0x00000007, `div_zero` = 1 with `done`.
- **Signed divide overflow:** `div` A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0, `div_zero` = 0.
- **Control and abort behaviour:**
  - `mthi` 0x1234 in IDLE → `hi` = 0x1234 the next cycle.
  - `start` `mult` 5×5, then `cancel` at cycle 10 → IDLE at cycle 11, no `done`, `hi` stays 0x1234.
  - Repeat and drop `resetn` at cycle 20 → all outputs read 0 the next cycle.
  - `start` asserted while `busy` → ignored.
